// File: rtl/rx_udp_ctrl_pkg.sv
// Shared FSM encoding and counter constants for the UDP RX port-binding controller.
package rx_udp_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StDrop
  } state_e;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority matcher: lowest enabled table entry whose port equals dst_port.
module udp_port_match #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned PW     = 16
) (
  input  logic [NUM_CH*PW-1:0] tbl_port,
  input  logic [NUM_CH-1:0]    tbl_en,
  input  logic [PW-1:0]        dst_port,
  output logic                 hit,
  output logic [CH_W-1:0]      idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (tbl_en[i] && (tbl_port[i*PW +: PW] == dst_port)) begin
        hit = 1'b1;
        idx = i[CH_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rx_udp_port_ctrl.sv
// UDP RX port-binding controller: matches dst port at frame start and steers payload bytes.
// Optional per-channel frame counters are built when STATS_EN is defined.
module rx_udp_port_ctrl
  import rx_udp_ctrl_pkg::*;
#(
  parameter int unsigned OCT    = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic                    RX_CLK,
  input  logic                    rst_n,
  input  logic                    func_en,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_idx,
  input  logic [OCT*2-1:0]        cfg_port,
  input  logic                    cfg_en,
  input  logic [OCT*2-1:0]        rx_udp_dst_port,
  input  logic                    rx_udp_data_v,
  input  logic [OCT-1:0]          rx_udp_data,
  output logic [NUM_CH-1:0]       ch_data_v,
  output logic [OCT-1:0]          ch_data,
  output logic                    ch_sop,
  output logic                    ch_eop,
  output logic [CH_W-1:0]         ch_sel,
  output logic [NUM_CH-1:0]       ch_irq,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] stats_frames
);

  localparam int unsigned PW = OCT * 2;

  // Binding table
  logic [PW-1:0]        port_q [NUM_CH];
  logic [NUM_CH-1:0]    en_q;
  logic [NUM_CH*PW-1:0] tbl_port;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_tbl
    assign tbl_port[i*PW +: PW] = port_q[i];

    always_ff @(posedge RX_CLK or negedge rst_n) begin
      if (!rst_n) begin
        port_q[i] <= '0;
        en_q[i]   <= 1'b0;
      end else if (cfg_we && (cfg_idx == i[CH_W-1:0])) begin
        port_q[i] <= cfg_port;
        en_q[i]   <= cfg_en;
      end
    end
  end

  logic            hit;
  logic [CH_W-1:0] hit_idx;

  udp_port_match #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .PW     (PW)
  ) u_match (
    .tbl_port (tbl_port),
    .tbl_en   (en_q),
    .dst_port (rx_udp_dst_port),
    .hit      (hit),
    .idx      (hit_idx)
  );

  // Frame FSM
  state_e          state_q, state_d;
  logic [CH_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic            data_v_q;
  logic            start;
  logic            fwd_start;

  assign start = rx_udp_data_v & ~data_v_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    drop_d    = drop_q;
    fwd_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (func_en && hit) begin
            state_d   = StFwd;
            sel_d     = hit_idx;
            fwd_start = 1'b1;
          end else begin
            state_d = StDrop;
            // A disabled block swallows the frame without counting it as unmatched.
            if (func_en) drop_d = sat_inc(drop_q);
          end
        end
      end
      StFwd, StDrop: begin
        if (!rx_udp_data_v) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      drop_q   <= '0;
      data_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      drop_q   <= drop_d;
      data_v_q <= rx_udp_data_v;
    end
  end

  // Stage 1
  logic           s1_v_q, s1_first_q;
  logic [OCT-1:0] s1_data_q;

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_v_q     <= fwd_start | ((state_q == StFwd) & rx_udp_data_v);
      s1_first_q <= fwd_start;
      s1_data_q  <= rx_udp_data;
    end
  end

  // Stage 2
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] ch_data_v_q, ch_irq_q;
  logic [OCT-1:0]    ch_data_q;
  logic              ch_sop_q, ch_eop_q;
  logic [CH_W-1:0]   ch_sel_q;

  always_comb begin
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      ch_data_v_q <= '0;
      ch_data_q   <= '0;
      ch_sop_q    <= 1'b0;
      ch_eop_q    <= 1'b0;
      ch_sel_q    <= '0;
      ch_irq_q    <= '0;
    end else begin
      ch_data_v_q <= s1_v_q ? sel_oh : '0;
      if (s1_v_q) ch_data_q <= s1_data_q;
      ch_sop_q    <= s1_first_q;
      // The byte in stage 1 is the last one when the input has already gone quiet.
      ch_eop_q    <= s1_v_q & ~rx_udp_data_v;
      if (s1_first_q) ch_sel_q <= sel_q;
      ch_irq_q    <= ch_eop_q ? ch_data_v_q : '0;
    end
  end

  assign ch_data_v = ch_data_v_q;
  assign ch_data   = ch_data_q;
  assign ch_sop    = ch_sop_q;
  assign ch_eop    = ch_eop_q;
  assign ch_sel    = ch_sel_q;
  assign ch_irq    = ch_irq_q;
  assign drop_cnt  = drop_q;
  assign busy      = (state_q != StIdle) | s1_v_q | (|ch_data_v_q);

`ifdef STATS_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_stats
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge RX_CLK or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (ch_eop_q && ch_data_v_q[i]) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end

    assign stats_frames[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign stats_frames = '0;
`endif

endmodule

// File: tb/tb_rx_udp_port_ctrl.sv
// Directed bench for rx_udp_port_ctrl with a byte-level scoreboard on the channel outputs.
module tb_rx_udp_port_ctrl;

  localparam int unsigned OCT    = 8;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  logic                 RX_CLK = 1'b0;
  logic                 rst_n;
  logic                 func_en;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_idx;
  logic [15:0]          cfg_port;
  logic                 cfg_en;
  logic [15:0]          rx_udp_dst_port;
  logic                 rx_udp_data_v;
  logic [7:0]           rx_udp_data;
  logic [NUM_CH-1:0]    ch_data_v;
  logic [7:0]           ch_data;
  logic                 ch_sop;
  logic                 ch_eop;
  logic [CH_W-1:0]      ch_sel;
  logic [NUM_CH-1:0]    ch_irq;
  logic [15:0]          drop_cnt;
  logic                 busy;
  logic [NUM_CH*16-1:0] stats_frames;

  rx_udp_port_ctrl #(
    .OCT    (OCT),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) dut (
    .RX_CLK          (RX_CLK),
    .rst_n           (rst_n),
    .func_en         (func_en),
    .cfg_we          (cfg_we),
    .cfg_idx         (cfg_idx),
    .cfg_port        (cfg_port),
    .cfg_en          (cfg_en),
    .rx_udp_dst_port (rx_udp_dst_port),
    .rx_udp_data_v   (rx_udp_data_v),
    .rx_udp_data     (rx_udp_data),
    .ch_data_v       (ch_data_v),
    .ch_data         (ch_data),
    .ch_sop          (ch_sop),
    .ch_eop          (ch_eop),
    .ch_sel          (ch_sel),
    .ch_irq          (ch_irq),
    .drop_cnt        (drop_cnt),
    .busy            (busy),
    .stats_frames    (stats_frames)
  );

  always #5 RX_CLK = ~RX_CLK;

  typedef struct {
    int       ch;
    logic [7:0] data;
    bit       sop;
    bit       eop;
    int       t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  int   m_port [NUM_CH];
  bit   m_en [NUM_CH];
  int   m_drop;
  int   m_sel;
  int   m_stats [NUM_CH];

  always @(posedge RX_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH-1:0] onehot(input int ch);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  function automatic int find(input int port);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_en[i] && (m_port[i] == port)) return i;
    end
    return -1;
  endfunction

  // Output monitor: pops one expected byte per valid output cycle, checks irq alignment.
  logic [NUM_CH-1:0] exp_irq;
  always @(negedge RX_CLK) begin
    exp_t it;
    if (!mon_en) begin
      exp_irq = '0;
    end else begin
      chk("irq", 64'(ch_irq), 64'(exp_irq));
      exp_irq = '0;
      if (|ch_data_v) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(ch_data_v), 64'd0);
        end else begin
          it = q.pop_front();
          chk("data_v", 64'(ch_data_v), 64'(onehot(it.ch)));
          chk("data", 64'(ch_data), 64'(it.data));
          chk("sop", 64'(ch_sop), 64'(it.sop));
          chk("eop", 64'(ch_eop), 64'(it.eop));
          chk("latency", 64'(cyc), 64'(it.t));
          if (it.eop) exp_irq = onehot(it.ch);
        end
      end
    end
  end

  task automatic cfg_write(input int idx, input int port, input bit en);
    @(posedge RX_CLK); #1;
    cfg_we = 1'b1; cfg_idx = idx[CH_W-1:0]; cfg_port = port[15:0]; cfg_en = en;
    m_port[idx] = port; m_en[idx] = en;
    @(posedge RX_CLK); #1;
    cfg_we = 1'b0;
  endtask

  // Drives one contiguous frame; optionally rewrites a table entry at byte wr_at.
  task automatic send_frame(input int port, input int len, input int wr_at = -1,
                            input int wr_idx = 0, input int wr_port = 0);
    int   ch;
    exp_t it;
    ch = func_en ? find(port) : -1;
    if (ch >= 0) m_sel = ch;
    else if (func_en) m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 1;
    for (int k = 0; k < len; k++) begin
      @(posedge RX_CLK); #1;
      rx_udp_data_v = 1'b1;
      rx_udp_dst_port = port[15:0];
      rx_udp_data = 8'($urandom);
      if (k == wr_at) begin
        cfg_we = 1'b1; cfg_idx = wr_idx[CH_W-1:0]; cfg_port = wr_port[15:0]; cfg_en = 1'b1;
        m_port[wr_idx] = wr_port; m_en[wr_idx] = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      if (k == 1) chk("busy_mid", 64'(busy), 64'd1);
      if (ch >= 0) begin
        it.ch = ch; it.data = rx_udp_data; it.sop = (k == 0); it.eop = (k == len - 1);
        it.t = cyc + 2;
        q.push_back(it);
      end
    end
    if ((ch >= 0) && (m_stats[ch] != 16'hFFFF)) m_stats[ch]++;
    @(posedge RX_CLK); #1;
    rx_udp_data_v = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [NUM_CH*16-1:0] st;
    repeat (5) @(posedge RX_CLK);
    @(negedge RX_CLK); #1;
    chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    q.delete();
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
    chk({tag, "_sel"}, 64'(ch_sel), 64'(m_sel));
    st = '0;
`ifdef STATS_EN
    for (int i = 0; i < NUM_CH; i++) st[i*16 +: 16] = m_stats[i][15:0];
`endif
    chk({tag, "_stats"}, 64'(stats_frames), 64'(st));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_port[i] = 0; m_en[i] = 1'b0; m_stats[i] = 0;
    end
    m_drop = 0;
    m_sel = 0;
  endtask

  initial begin
    rst_n = 1'b0; func_en = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_port = '0; cfg_en = 1'b0;
    rx_udp_dst_port = '0; rx_udp_data_v = 1'b0; rx_udp_data = '0;
    model_reset();

    // Reset state
    #12;
    chk("rst_data_v", 64'(ch_data_v), 64'd0);
    chk("rst_sop_eop", 64'({ch_sop, ch_eop}), 64'd0);
    chk("rst_irq", 64'(ch_irq), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sel", 64'(ch_sel), 64'd0);
    chk("rst_stats", 64'(stats_frames), 64'd0);
    @(posedge RX_CLK); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Basic forward on channel 1
    cfg_write(1, 5000, 1'b1);
    send_frame(5000, 10);
    drain("fwd10");

    // Priority: lowest enabled index wins
    cfg_write(0, 53, 1'b1);
    cfg_write(2, 53, 1'b1);
    send_frame(53, 4);
    drain("prio0");
    cfg_write(0, 53, 1'b0);
    send_frame(53, 5);
    drain("prio2");

    // Unbound port is dropped and counted
    send_frame(9999, 6);
    drain("unbound");

    // Disabled block drops without counting
    func_en = 1'b0;
    send_frame(5000, 3);
    func_en = 1'b1;
    drain("func_off");

    // 1-byte frame then 3-byte frame after a single idle cycle
    send_frame(5000, 1);
    send_frame(5000, 3);
    drain("short");

    // Rebind channel 1 mid-frame: current frame stays on channel 1
    send_frame(5000, 8, 3, 1, 6000);
    drain("rebind_cur");
    send_frame(6000, 4);
    drain("rebind_new");
    send_frame(5000, 2);
    drain("rebind_old");

    // Drop counter saturation
    @(posedge RX_CLK); #1;
    force dut.drop_q = 16'hFFFE;
    @(posedge RX_CLK); #1;
    release dut.drop_q;
    m_drop = 16'hFFFE;
    @(negedge RX_CLK);
    chk("preload_drop", 64'(drop_cnt), 64'hFFFE);
    send_frame(9999, 2);
    drain("sat1");
    send_frame(9999, 2);
    drain("sat2");

    // Reset in the middle of a forwarded frame on channel 2
    mon_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge RX_CLK); #1;
      rx_udp_data_v = 1'b1; rx_udp_dst_port = 16'd53; rx_udp_data = 8'(k + 1);
    end
    chk("pre_rst_valid", 64'(|ch_data_v), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data_v", 64'(ch_data_v), 64'd0);
    chk("mid_rst_eop", 64'(ch_eop), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    rx_udp_data_v = 1'b0;
    model_reset();
    @(posedge RX_CLK); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge RX_CLK);
      chk("post_rst_quiet", 64'({ch_irq, ch_data_v, ch_eop}), 64'd0);
    end
    mon_en = 1'b1;
    send_frame(53, 3);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rx_udp_port_ctrl.md
Name: rx_udp_port_ctrl

Overview:
Port-binding controller and payload dispatcher behind the UDP receiver.
- Holds a table of NUM_CH bound destination ports, written by a simple config interface.
- At the start of each UDP payload, matches the header destination port against the table.
- Routes the byte stream to one consumer channel (one-hot valid), or drops it and counts the drop.
- Sits between rx_udp and the per-application consumers, in the RX_CLK domain.

Parameters:
OCT, 8, data byte width
NUM_CH, 4, number of consumer channels / table entries (power of 2, 2..16)
CH_W, 2, log2(NUM_CH), width of the channel index

Ports:
RX_CLK  in  1  receive clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
func_en  in  1  block enable; 0 = no new frame accepted
cfg_we  in  1  table write strobe
cfg_idx  in  CH_W  table entry to write
cfg_port  in  OCT*2  port number for entry
cfg_en  in  1  entry enable bit
rx_udp_dst_port  in  OCT*2  header destination port from the UDP receiver; stable while rx_udp_data_v=1
rx_udp_data_v  in  1  payload byte valid; contiguous per frame; at least 1 low cycle between frames
rx_udp_data  in  OCT  payload byte
ch_data_v  out  NUM_CH  one-hot byte valid for the selected channel
ch_data  out  OCT  payload byte, shared by all channels
ch_sop  out  1  first byte of frame (qualified by |ch_data_v)
ch_eop  out  1  last byte of frame (qualified by |ch_data_v)
ch_sel  out  CH_W  index of the currently/last selected channel
ch_irq  out  NUM_CH  1-cycle pulse per channel, one cycle after its eop byte
drop_cnt  out  16  count of unmatched frames, saturating
busy  out  1  frame in progress (state != IDLE or pipeline valid)
stats_frames  out  NUM_CH*16  per-channel forwarded-frame counts (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): table entries cleared (port=0, en=0); all outputs 0; state IDLE; pipeline registers cleared. Reset asserted mid-frame aborts the frame and emits no eop or irq.
- Table write: when cfg_we=1, entry[cfg_idx] <= {cfg_en, cfg_port} on the next edge. Writes are accepted in any state.
- The binding is latched at frame start, so a write during a frame affects only later frames.
- Match rule: the lowest index i with en[i]=1 and port[i]==rx_udp_dst_port. Port 0 is matchable when enabled.
- FSM states:
  - IDLE: on rising edge of rx_udp_data_v (prev=0, cur=1) with func_en=1:
    - match found: latch sel=i and go to FWD;
    - no match: go to DROP and increment drop_cnt, saturating at 16'hFFFF.
  - IDLE with func_en=0 at the rising edge: go to DROP, but drop_cnt is not incremented.
  - FWD / DROP: stay while rx_udp_data_v=1; return to IDLE on the first cycle rx_udp_data_v=0.
  - func_en falling mid-frame does not truncate the frame.
- Datapath: 2-cycle latency, from input byte at edge t to output at edge t+2.
  - Stage 1 registers data, valid (FWD or match-at-start), and first flag.
  - Stage 2 drives the outputs:
    - ch_data_v = onehot(sel) when the stage-1 valid is set;
    - ch_sop = stage-1 first flag;
    - ch_eop = stage-1 valid & !rx_udp_data_v.
  - A 1-byte frame gives sop=eop=1 on the same cycle.
- Dropped bytes never assert ch_data_v.
- ch_irq[sel] pulses for 1 cycle on the cycle after the eop output.
- ch_sel holds its value between frames.

Optional Feature:
STATS_EN
- Defined: per-channel 16-bit frame counters increment on each forwarded eop, saturating at 16'hFFFF, cleared by reset; presented on stats_frames (channel i at bits [16*i+15:16*i]).
- Not defined: no counters are built and stats_frames is tied to 0.

Decomposition:
- Package rx_udp_ctrl_pkg: FSM state encoding (IDLE, FWD, DROP); CNT_W=16; CNT_MAX=16'hFFFF.
- Sub-module udp_port_match: combinational priority matcher.
  - Inputs: flat table and dst port.
  - Outputs: hit and idx.
  - Instantiated once.

Test Plan:
- Entry1=port 5000, en=1; 10-byte frame to dst 5000 -> ch_data_v=4'b0010 for 10 cycles starting 2 cycles after the first input byte; sop on byte 0, eop on byte 9; ch_irq[1] pulses on the next cycle.
- Entries 0 and 2 both bound to 53, both enabled; frame to 53 -> channel 0 selected; disable entry 0, next frame -> channel 2.
- Frame to an unbound port 9999 -> no ch_data_v, drop_cnt 0->1; preload 65535 drops -> drop_cnt stays 16'hFFFF.
- 1-byte frame followed after 1 idle cycle by a 3-byte frame, same port -> sop&eop together, then a sop..eop span of 3 cycles; 2 irq pulses.
- cfg write rebinding the active channel to another port mid-frame -> current frame completes on the old channel; the next frame uses the new binding.
- rst_n low in the middle of a forwarded frame -> all outputs 0 immediately; no eop/irq; table cleared, so a subsequent frame is dropped. With STATS_EN, stats for the channel count only completed frames.
